// File: rtl/simon_round_controller_pkg.sv
// Shared types and constants for the Simon round sequencer.
// Holds the FSM state encoding, bus widths and the colour codes.
package simon_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 2;

   localparam logic [DATA_W-1:0] COLOR_RED    = 2'd0;
   localparam logic [DATA_W-1:0] COLOR_GREEN  = 2'd1;
   localparam logic [DATA_W-1:0] COLOR_BLUE   = 2'd2;
   localparam logic [DATA_W-1:0] COLOR_YELLOW = 2'd3;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      WAIT_LOAD = 4'd1,
      PB_ADDR   = 4'd2,
      PB_DATA   = 4'd3,
      SHOW      = 4'd4,
      GAP       = 4'd5,
      IN_ADDR   = 4'd6,
      IN_DATA   = 4'd7,
      IN_WAIT   = 4'd8,
      WIN       = 4'd9,
      FAIL      = 4'd10
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/simon_round_controller_tick_timer.sv
// Counts tick pulses since the last clear and flags the tick that
// reaches the selected terminal count.
module tick_timer #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             tick,
   input  logic [CNT_W-1:0] terminal,
   output logic             done
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (tick) begin
         count <= count + 1'b1;
      end
   end

   assign done = tick && (count == (terminal - 1'b1));

endmodule

// File: rtl/simon_round_controller.sv
// Simon game sequencer: plays the first round_len ROM entries on the LEDs,
// then checks the player's presses against the ROM until win or fail.
module simon_round_controller
   import simon_pkg::*;
#(
   parameter int N             = 10,
   parameter int ON_TICKS      = 4,
   parameter int GAP_TICKS     = 2,
   parameter int TIMEOUT_TICKS = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic              start,
   input  logic              load_done,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              btn_valid,
   input  logic [DATA_W-1:0] btn_code,
   output logic              led_en,
   output logic [DATA_W-1:0] led_code,
   output logic [ADDR_W-1:0] round_len,
   output logic              playing,
   output logic              awaiting_input,
   output logic              win,
   output logic              fail,
   output logic [3:0]        state_dbg
);

   localparam int CNT_W = $clog2(max3(ON_TICKS, GAP_TICKS, TIMEOUT_TICKS)) + 1;
   localparam logic [CNT_W-1:0]  ON_TERM   = CNT_W'(ON_TICKS);
   localparam logic [CNT_W-1:0]  GAP_TERM  = CNT_W'(GAP_TICKS);
   localparam logic [CNT_W-1:0]  TO_TERM   = CNT_W'(TIMEOUT_TICKS);
   localparam logic [ADDR_W-1:0] LAST_LEN  = ADDR_W'(N);
   localparam logic [ADDR_W-1:0] FIRST_LEN = ADDR_W'(1);

   state_t            state, state_next;
   logic [ADDR_W-1:0] idx, idx_next;
   logic [ADDR_W-1:0] round_len_next;
   logic [DATA_W-1:0] cur, cur_next;
   logic [CNT_W-1:0]  term;
   logic              timer_clear;
   logic              timer_done;
   logic              last_step;

   // One counter serves SHOW, GAP and IN_WAIT; it restarts on every state change.
   always_comb begin
      term = TO_TERM;
      case (state)
         SHOW:    term = ON_TERM;
         GAP:     term = GAP_TERM;
         default: term = TO_TERM;
      endcase
   end

   assign timer_clear = (state_next != state) ||
                        !((state == SHOW) || (state == GAP) || (state == IN_WAIT));

   tick_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clear),
      .tick    (tick),
      .terminal(term),
      .done    (timer_done)
   );

   assign last_step = !(idx < (round_len - FIRST_LEN));

   always_comb begin
      state_next     = state;
      idx_next       = idx;
      round_len_next = round_len;
      cur_next       = cur;
      case (state)
         IDLE: begin
            if (start) state_next = WAIT_LOAD;
         end
         WAIT_LOAD: begin
            if (load_done) begin
               state_next = PB_ADDR;
               idx_next   = '0;
            end
         end
         PB_ADDR: state_next = PB_DATA;
         PB_DATA: begin
            cur_next   = rd_data;
            state_next = SHOW;
         end
         SHOW: begin
            if (timer_done) state_next = GAP;
         end
         GAP: begin
            if (timer_done) begin
               if (!last_step) begin
                  idx_next   = idx + 1'b1;
                  state_next = PB_ADDR;
               end else begin
                  idx_next   = '0;
                  state_next = IN_ADDR;
               end
            end
         end
         IN_ADDR: state_next = IN_DATA;
         IN_DATA: begin
            cur_next   = rd_data;
            state_next = IN_WAIT;
         end
         IN_WAIT: begin
            // A press on the terminal tick still counts; the timeout only fires without one.
            if (btn_valid) begin
               if (btn_code != cur) begin
                  state_next = FAIL;
               end else if (!last_step) begin
                  idx_next   = idx + 1'b1;
                  state_next = IN_ADDR;
               end else if (round_len == LAST_LEN) begin
                  state_next = WIN;
               end else begin
                  round_len_next = round_len + 1'b1;
                  idx_next       = '0;
                  state_next     = PB_ADDR;
               end
            end else if (timer_done) begin
               state_next = FAIL;
            end
         end
         WIN, FAIL: begin
            if (start) begin
               round_len_next = FIRST_LEN;
               idx_next       = '0;
               state_next     = WAIT_LOAD;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         idx       <= '0;
         round_len <= FIRST_LEN;
         cur       <= '0;
      end else begin
         state     <= state_next;
         idx       <= idx_next;
         round_len <= round_len_next;
         cur       <= cur_next;
      end
   end

   // Outputs are flops loaded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_addr        <= '0;
         led_en         <= 1'b0;
         led_code       <= '0;
         playing        <= 1'b0;
         awaiting_input <= 1'b0;
         win            <= 1'b0;
         fail           <= 1'b0;
      end else begin
         if ((state_next == PB_ADDR) || (state_next == IN_ADDR)) begin
            rd_addr <= idx_next;
         end
         led_en         <= (state_next == SHOW);
         led_code       <= (state_next == SHOW) ? cur_next : '0;
         playing        <= (state_next == PB_ADDR) || (state_next == PB_DATA) ||
                           (state_next == SHOW)    || (state_next == GAP);
         awaiting_input <= (state_next == IN_WAIT);
         win            <= (state_next == WIN);
         fail           <= (state_next == FAIL);
      end
   end

   assign state_dbg = state;

endmodule

// File: doc/simon_round_controller.md
Name: simon_round_controller

Overview:
Game sequencer for the Simon datapath. After the sequence loader fills the sequence ROM, this block plays the first round_len entries on the LEDs. It then checks player button presses against the ROM contents. A correct round grows the round length, and finishing round N asserts win. A wrong press or an input timeout asserts fail. It is the only reader of the sequence ROM and the only driver of the LED code bus.

Parameters:
N, 10, sequence length and final round; legal range 1..15 (4-bit address)
ON_TICKS, 4, tick pulses an LED stays lit per step
GAP_TICKS, 2, tick pulses of dark gap after each step
TIMEOUT_TICKS, 20, tick pulses allowed between player presses

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  single-cycle timing pulse; all durations are counted in ticks
start  in  1  single-cycle pulse; begins a game from IDLE, WIN or FAIL
load_done  in  1  level; sequence ROM is fully loaded
rd_addr  out  4  sequence ROM read address
rd_data  in  2  ROM data; valid the cycle after rd_addr is registered
btn_valid  in  1  single-cycle pulse; a debounced press is present
btn_code  in  2  colour of the press; qualified by btn_valid
led_en  out  1  lights the LED selected by led_code
led_code  out  2  colour being shown
round_len  out  4  current round length, 1..N
playing  out  1  high during playback states
awaiting_input  out  1  high in IN_WAIT
win  out  1  level; held in WIN
fail  out  1  level; held in FAIL

Behaviour:
- Reset (async, active-low):
  - state=IDLE, round_len=1, idx=0, tick counters=0.
  - All outputs 0, except round_len=1.
- All outputs are registered. No combinational path from input to output.
- IDLE: start -> WAIT_LOAD.
- WAIT_LOAD: load_done=1 -> PB_ADDR with idx=0. load_done already high at entry -> leave on the next cycle.
- PB_ADDR (1 cycle): rd_addr<=idx.
- PB_DATA (1 cycle): cur<=rd_data.
- SHOW: led_en=1, led_code=cur. Exit after ON_TICKS tick pulses -> GAP.
- GAP: led_en=0. Exit after GAP_TICKS pulses.
  - If idx<round_len-1: idx++ -> PB_ADDR.
  - Else: idx=0, clear timeout counter -> IN_ADDR.
- IN_ADDR / IN_DATA: same 2-cycle ROM read as playback, captures expected value.
- IN_WAIT: awaiting_input=1.
  - btn_valid with btn_code==expected:
    - If idx<round_len-1: idx++, clear timeout -> IN_ADDR.
    - Else if round_len==N -> WIN.
    - Else: round_len++, idx=0 -> PB_ADDR.
  - btn_valid with a mismatched code -> FAIL.
  - Timeout counter reaches TIMEOUT_TICKS with no press -> FAIL.
  - btn_valid and the terminal tick in the same cycle: the press wins; timeout is ignored.
- btn_valid outside IN_WAIT: ignored. This includes IN_ADDR/IN_DATA, so a press arriving during a fetch is dropped.
- tick outside SHOW/GAP/IN_WAIT: ignored. The relevant counter clears on every entry to SHOW, GAP and IN_WAIT.
- WIN / FAIL:
  - Hold win=1 or fail=1, led_en=0.
  - start -> round_len=1, flags cleared -> WAIT_LOAD. The ROM contents are replayed unchanged.
- start in any other state: ignored.
- Reset mid-game: returns to IDLE within the same cycle, with LEDs off.
- playing=1 in PB_ADDR, PB_DATA, SHOW and GAP.
- Width rules:
  - idx and round_len are 4 bits.
  - round_len never exceeds N; there is no wrap.
  - Tick counters are sized by clog2 of the maximum of ON_TICKS, GAP_TICKS and TIMEOUT_TICKS, plus 1.
- Minimum latency: start with load_done already high -> LED lit 3 cycles after start (WAIT_LOAD, PB_ADDR, PB_DATA).

Decomposition:
- Package simon_pkg holds:
  - the state enum (IDLE, WAIT_LOAD, PB_ADDR, PB_DATA, SHOW, GAP, IN_ADDR, IN_DATA, IN_WAIT, WIN, FAIL);
  - ADDR_W=4 and DATA_W=2;
  - colour code constants 0..3.
- One sub-module, tick_timer:
  - inputs: clear, tick, terminal count;
  - output: done pulse on the tick that reaches the terminal count.
  - Instantiated once and shared by SHOW, GAP and IN_WAIT via terminal-count selection.

Test Plan:
Common setup: N=3, ON_TICKS=2, GAP_TICKS=1, TIMEOUT_TICKS=5, ROM={2,0,3}, tick every 4 cycles.
1. Reset, start, load_done raised 10 cycles later -> rd_addr=0, then led_en=1 with led_code=2 for exactly 2 ticks, then dark for 1 tick, then awaiting_input=1 with round_len=1.
2. Full correct game: presses 2 / 2,0 / 2,0,3 across rounds 1-3 -> round_len steps 1,2,3; round 2 plays 2 then 0; win=1 after the last press; fail stays 0.
3. Round 2, presses 2 then 1 -> fail=1 on the cycle after the wrong press; led_en=0; later presses ignored.
4. Round 1, no press for 5 ticks -> fail=1. A second run with the press landing on the 5th tick cycle -> accepted, no fail.
5. btn_valid during SHOW and during IN_DATA -> ignored; state and idx are unchanged.
6. Reset asserted mid-SHOW in round 2 -> all outputs 0 and round_len=1 immediately. After a win, start replays from round 1 with the same ROM values.
